// File: rtl/bg_pix_fifo.sv
// ---------------------------------------------------------------------------
// bg_pix_fifo
//
// Pixel prefetch stage that sits directly behind one BG renderer. It paces the
// renderer with seed / move / request strobes and captures every RGB write,
// along with the renderer's offscreen flag, into a show-ahead FIFO. The layer
// mixer then pops pixels from that FIFO with a read strobe. One scan line is
// fetched per video-timing line start.
//
// Parameters
//   pDEPTH           FIFO entries (power of two, at least 2)
//   pLINE_PIX        pixels fetched per line
//
// Ports
//   iCLOCK           clock
//   iRESET           synchronous, active-high reset
//   iFRAME_START     marks a coincident iLINE_START as line 0 of a frame
//   iLINE_START      video timing pulse: begin fetching a new line
//   oPIX_MOVE        to BG iPIX_MOVE
//   oSTART           to BG iSTART (frame seed)
//   oLINE_START      to BG iLINE_START (line seed)
//   oRGB_REQ         to BG iRGB_REQ, one-cycle request pulse
//   iRGB_WRITE       from BG oRGB_WRITE (level, may stay high after a write)
//   iRGB_WRITE_DATA  from BG, 16-bit RGB
//   iOFFSCREEN       from BG oOFFSCREEN
//   iPIX_RD          mixer pops the head entry
//   oPIX_VALID       FIFO not empty
//   oPIX_RGB         head RGB (0 when empty)
//   oPIX_OFFSCREEN   head offscreen flag (1 when empty)
//   oLINE_DONE       every pixel of the current line has been pushed
//   oUNDERFLOW       sticky flag: mixer read an empty FIFO
// ---------------------------------------------------------------------------
module bg_pix_fifo #(
    parameter int pDEPTH    = 16,
    parameter int pLINE_PIX = 320
) (
    input  logic        iCLOCK,
    input  logic        iRESET,
    input  logic        iFRAME_START,
    input  logic        iLINE_START,
    output logic        oPIX_MOVE,
    output logic        oSTART,
    output logic        oLINE_START,
    output logic        oRGB_REQ,
    input  logic        iRGB_WRITE,
    input  logic [15:0] iRGB_WRITE_DATA,
    input  logic        iOFFSCREEN,
    input  logic        iPIX_RD,
    output logic        oPIX_VALID,
    output logic [15:0] oPIX_RGB,
    output logic        oPIX_OFFSCREEN,
    output logic        oLINE_DONE,
    output logic        oUNDERFLOW
);

    localparam int pAW = $clog2(pDEPTH);
    localparam int pCW = pAW + 1;
    localparam int pPW = $clog2(pLINE_PIX + 1);

    localparam logic [pCW-1:0] cDepth   = pCW'(pDEPTH);
    localparam logic [pPW-1:0] cLinePix = pPW'(pLINE_PIX);

    typedef enum logic [2:0] {
        sIDLE,
        sSEED,
        sREQ,
        sWAIT,
        sMOVE,
        sDONE
    } tState;

    tState          state;
    logic           pending;
    logic           pendingFrame;
    logic           seedFrame;
    logic [pPW-1:0] pixCount;
    logic           writePrev;

    logic [16:0]    fifoMem [pDEPTH];
    logic [pAW-1:0] wrPtr;
    logic [pAW-1:0] rdPtr;
    logic [pCW-1:0] fifoCount;
    logic [16:0]    headEntry;

    logic           writeRise;
    logic           lineReq;
    logic           lineFrame;
    logic           seedGo;
    logic           pushEn;
    logic           popEn;
    logic           flushEn;
    logic           underflowHit;

    // Control decisions shared by the sequencer and the FIFO.
    // The renderer holds oRGB_WRITE as a level, so only a rising edge counts
    // as a new write; otherwise a held level would be pushed again on the
    // next request. A line start arriving this very cycle is treated exactly
    // like one that was latched earlier, and the newest pulse decides whether
    // the reseed is a frame seed. A reseed from sWAIT only happens once the
    // renderer has finished its fetch, and that fetched pixel is dropped.
    always_comb begin
        writeRise    = iRGB_WRITE & ~writePrev;
        lineReq      = pending | iLINE_START;
        lineFrame    = iLINE_START ? iFRAME_START : pendingFrame;
        seedGo       = 1'b0;
        case (state)
            sIDLE, sDONE: seedGo = iLINE_START;
            sREQ, sMOVE:  seedGo = lineReq;
            sWAIT:        seedGo = writeRise & lineReq;
            default:      seedGo = 1'b0;
        endcase
        pushEn       = (state == sWAIT) & writeRise & ~lineReq;
        popEn        = iPIX_RD & (fifoCount != '0);
        flushEn      = (state == sSEED);
        underflowHit = iPIX_RD & (fifoCount == '0);
    end

    // Line sequencer. Every strobe is registered and is set on the transition
    // into the state that owns it, so oPIX_MOVE/oSTART/oLINE_START line up
    // with sSEED and sMOVE, oLINE_DONE lines up with sDONE, and oRGB_REQ is a
    // single pulse in the first sWAIT cycle. Only one request is ever in
    // flight and a request is only made with a free FIFO slot, so a push can
    // never find the FIFO full. Mid-line line starts are remembered in
    // 'pending' until the sequencer reaches a point where it can reseed.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            state        <= sIDLE;
            oPIX_MOVE    <= 1'b0;
            oSTART       <= 1'b0;
            oLINE_START  <= 1'b0;
            oRGB_REQ     <= 1'b0;
            oLINE_DONE   <= 1'b0;
            pending      <= 1'b0;
            pendingFrame <= 1'b0;
            seedFrame    <= 1'b0;
            pixCount     <= '0;
            writePrev    <= 1'b0;
        end else begin
            writePrev   <= iRGB_WRITE;
            oPIX_MOVE   <= 1'b0;
            oSTART      <= 1'b0;
            oLINE_START <= 1'b0;
            oRGB_REQ    <= 1'b0;
            oLINE_DONE  <= 1'b0;

            if (iLINE_START && (state != sIDLE) && (state != sDONE)) begin
                pending      <= 1'b1;
                pendingFrame <= iFRAME_START;
            end

            if (seedGo) begin
                state       <= sSEED;
                oPIX_MOVE   <= 1'b1;
                oSTART      <= lineFrame;
                oLINE_START <= ~lineFrame;
                seedFrame   <= lineFrame;
                pending     <= 1'b0;
            end else begin
                case (state)
                    sIDLE: begin
                        state <= sIDLE;
                    end
                    sSEED: begin
                        pixCount <= '0;
                        state    <= sREQ;
                    end
                    sREQ: begin
                        if (fifoCount < cDepth) begin
                            oRGB_REQ <= 1'b1;
                            state    <= sWAIT;
                        end
                    end
                    sWAIT: begin
                        if (pushEn) begin
                            pixCount  <= pixCount + 1'b1;
                            oPIX_MOVE <= 1'b1;
                            state     <= sMOVE;
                        end
                    end
                    sMOVE: begin
                        if (pixCount == cLinePix) begin
                            oLINE_DONE <= 1'b1;
                            state      <= sDONE;
                        end else begin
                            state <= sREQ;
                        end
                    end
                    sDONE: begin
                        oLINE_DONE <= 1'b1;
                    end
                    default: begin
                        state <= sIDLE;
                    end
                endcase
            end
        end
    end

    // FIFO storage. The array carries no reset: an entry is only visible once
    // the count says it has been written, and the empty case is masked at the
    // outputs below.
    always_ff @(posedge iCLOCK) begin
        if (pushEn) begin
            fifoMem[wrPtr] <= {iOFFSCREEN, iRGB_WRITE_DATA};
        end
    end

    // FIFO pointers and occupancy. The pointers wrap naturally at pDEPTH and
    // the count is one bit wider so that full and empty are distinct. The
    // flush at the line seed wins over a pop in the same cycle; a push and a
    // pop together leave the count unchanged.
    always_ff @(posedge iCLOCK) begin
        if (iRESET || flushEn) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else begin
            if (pushEn) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (popEn) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({pushEn, popEn})
                2'b10:   fifoCount <= fifoCount + 1'b1;
                2'b01:   fifoCount <= fifoCount - 1'b1;
                default: fifoCount <= fifoCount;
            endcase
        end
    end

    // Sticky underflow. It is raised whenever the mixer reads while the FIFO
    // is empty and is only cleared by reset or by a frame seed, so the error
    // stays visible for the rest of the frame. A new underflow in the clearing
    // cycle still wins.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            oUNDERFLOW <= 1'b0;
        end else begin
            if (flushEn && seedFrame) begin
                oUNDERFLOW <= 1'b0;
            end
            if (underflowHit) begin
                oUNDERFLOW <= 1'b1;
            end
        end
    end

    // Show-ahead outputs. When the FIFO is empty the mixer is handed a
    // transparent pixel (RGB 0, offscreen set) instead of stale storage.
    always_comb begin
        headEntry      = fifoMem[rdPtr];
        oPIX_VALID     = (fifoCount != '0);
        oPIX_RGB       = oPIX_VALID ? headEntry[15:0] : 16'h0000;
        oPIX_OFFSCREEN = oPIX_VALID ? headEntry[16] : 1'b1;
    end

endmodule

// File: tb/tb_bg_pix_fifo.sv
// ---------------------------------------------------------------------------
// tb_bg_pix_fifo
//
// Directed bench for bg_pix_fifo. A small BG renderer model answers each
// request after a fixed latency (optionally holding its write level high),
// and a mixer model pops pixels and checks them against the sequence the
// renderer model produced.
// ---------------------------------------------------------------------------
module tb_bg_pix_fifo;

   logic        clock;
   logic        reset;
   logic        frameStart;
   logic        lineStart;
   logic        pixMove;
   logic        seedStart;
   logic        seedLineStart;
   logic        rgbReq;
   logic        rgbWrite;
   logic [15:0] rgbWriteData;
   logic        offscreen;
   logic        pixRd;
   logic        pixValid;
   logic [15:0] pixRgb;
   logic        pixOffscreen;
   logic        lineDone;
   logic        underflow;

   int compared   = 0;
   int mismatched = 0;

   int latency    = 4;
   int holdCycles = 0;
   int offIdx     = -1;
   int queued     = 0;
   int latLeft    = 0;
   int holdLeft   = 0;
   int serial     = 0;
   bit discardNext = 0;
   bit pairArm     = 0;

   bit autoRead  = 0;
   bit forceRead = 0;

   logic [16:0] expQ[$];

   int lineMoves  = 0;
   int lineReqs   = 0;
   int linePops   = 0;
   int totalMoves = 0;
   int violations = 0;
   bit seedSeen   = 0;
   int movesBefore;

   logic [15:0] popRgbLog [8];
   logic        popOffLog [8];

   bg_pix_fifo #(
      .pDEPTH    (16),
      .pLINE_PIX (320)
   ) dut (
      .iCLOCK          (clock),
      .iRESET          (reset),
      .iFRAME_START    (frameStart),
      .iLINE_START     (lineStart),
      .oPIX_MOVE       (pixMove),
      .oSTART          (seedStart),
      .oLINE_START     (seedLineStart),
      .oRGB_REQ        (rgbReq),
      .iRGB_WRITE      (rgbWrite),
      .iRGB_WRITE_DATA (rgbWriteData),
      .iOFFSCREEN      (offscreen),
      .iPIX_RD         (pixRd),
      .oPIX_VALID      (pixValid),
      .oPIX_RGB        (pixRgb),
      .oPIX_OFFSCREEN  (pixOffscreen),
      .oLINE_DONE      (lineDone),
      .oUNDERFLOW      (underflow)
   );

   // Free-running 100 MHz clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard stop in case something never returns.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One clock cycle of the environment, evaluated on the falling edge:
   // watch the strobes, advance the renderer model, then let the mixer decide
   // whether to pop at the next rising edge.
   task automatic applyStimulus();
      logic [16:0] expHead;
      @(negedge clock);

      seedSeen = pixMove && (seedStart || seedLineStart);
      if ((seedStart || seedLineStart) && !pixMove) violations++;
      if (seedStart && seedLineStart) violations++;
      if (seedSeen) begin
         lineMoves = 0;
         lineReqs  = 0;
         linePops  = 0;
         serial    = 0;
         expQ.delete();
      end else if (pixMove) begin
         lineMoves++;
         totalMoves++;
      end
      if (rgbReq) begin
         lineReqs++;
         queued++;
      end

      if (rgbWrite) begin
         if (holdLeft == 0) rgbWrite = 1'b0;
         else holdLeft--;
      end else if (latLeft > 0) begin
         latLeft--;
         if (latLeft == 0) begin
            offscreen    = (serial == offIdx);
            rgbWriteData = offscreen ? 16'hBEEF : 16'(32'h1000 + serial);
            rgbWrite     = 1'b1;
            if (pairArm && expQ.size() == 8) begin
               forceRead = 1'b1;
               pairArm   = 1'b0;
            end
            if (discardNext) discardNext = 1'b0;
            else expQ.push_back({offscreen, rgbWriteData});
            serial++;
            holdLeft = holdCycles;
         end
      end else if (queued > 0) begin
         queued--;
         latLeft = latency;
      end

      pixRd = 1'b0;
      if (!seedSeen && ((autoRead && pixValid) || forceRead)) begin
         pixRd = 1'b1;
         if (pixValid) begin
            expHead = 17'h1FFFF;
            if (expQ.size() > 0) expHead = expQ.pop_front();
            checkOutput("popRgb", pixRgb, expHead[15:0]);
            checkOutput("popOff", pixOffscreen, expHead[16]);
            if (linePops < 8) begin
               popRgbLog[linePops] = pixRgb;
               popOffLog[linePops] = pixOffscreen;
            end
            linePops++;
         end
      end
      forceRead = 1'b0;
   endtask

   // Reset the DUT and the environment models, then check the reset values.
   task automatic doReset();
      reset      = 1'b1;
      lineStart  = 1'b0;
      frameStart = 1'b0;
      autoRead   = 1'b0;
      forceRead  = 1'b0;
      repeat (2) applyStimulus();
      rgbWrite    = 1'b0;
      queued      = 0;
      latLeft     = 0;
      holdLeft    = 0;
      serial      = 0;
      discardNext = 1'b0;
      pairArm     = 1'b0;
      expQ.delete();
      lineMoves = 0;
      lineReqs  = 0;
      linePops  = 0;
      reset     = 1'b0;
      checkOutput("rstStrobes", {pixMove, seedStart, seedLineStart, rgbReq}, 4'b0000);
      checkOutput("rstValid", pixValid, 1'b0);
      checkOutput("rstRgb", pixRgb, 16'h0000);
      checkOutput("rstOff", pixOffscreen, 1'b1);
      checkOutput("rstDone", lineDone, 1'b0);
      checkOutput("rstUnderflow", underflow, 1'b0);
   endtask

   // One-cycle line start pulse, optionally qualified as a frame start.
   task automatic pulseLine(input logic frame);
      frameStart = frame;
      lineStart  = 1'b1;
      applyStimulus();
      lineStart  = 1'b0;
      frameStart = 1'b0;
   endtask

   // Run until the line is reported done, bounded by a cycle budget.
   task automatic runUntilDone(input int bound);
      int n = 0;
      while (!lineDone && n < bound) begin
         applyStimulus();
         n++;
      end
      checkOutput("lineDoneReached", lineDone, 1'b1);
   endtask

   initial begin
      int n;
      reset        = 1'b1;
      frameStart   = 1'b0;
      lineStart    = 1'b0;
      rgbWrite     = 1'b0;
      rgbWriteData = 16'h0000;
      offscreen    = 1'b0;
      pixRd        = 1'b0;

      // Full line from a frame start with a reading mixer.
      doReset();
      autoRead = 1'b1;
      pulseLine(1'b1);
      checkOutput("t1SeedStart", seedStart, 1'b1);
      checkOutput("t1SeedMove", pixMove, 1'b1);
      checkOutput("t1SeedLineStart", seedLineStart, 1'b0);
      applyStimulus();
      checkOutput("t1SeedOneCycle", {seedStart, seedLineStart, pixMove}, 3'b000);
      runUntilDone(5000);
      checkOutput("t1MovesAfterSeed", lineMoves, 320);
      checkOutput("t1Requests", lineReqs, 320);
      repeat (20) applyStimulus();
      checkOutput("t1Pops", linePops, 320);
      checkOutput("t1Drained", pixValid, 1'b0);
      checkOutput("t1NoExtraReq", lineReqs, 320);
      checkOutput("t1DoneHeld", lineDone, 1'b1);

      // Mixer never reads: the FIFO fills to 16 and requests stop.
      doReset();
      pulseLine(1'b1);
      repeat (300) applyStimulus();
      checkOutput("t2Requests", lineReqs, 16);
      checkOutput("t2Valid", pixValid, 1'b1);
      checkOutput("t2Head", pixRgb, 16'h1000);
      repeat (50) applyStimulus();
      checkOutput("t2Stalled", lineReqs, 16);
      forceRead = 1'b1;
      applyStimulus();
      repeat (30) applyStimulus();
      checkOutput("t2OneMoreReq", lineReqs, 17);
      checkOutput("t2NextHead", pixRgb, 16'h1001);

      // Renderer holds its write level for 10 cycles after each write.
      doReset();
      holdCycles = 10;
      pulseLine(1'b0);
      checkOutput("t3SeedLineStart", seedLineStart, 1'b1);
      repeat (400) applyStimulus();
      checkOutput("t3Requests", lineReqs, 16);
      checkOutput("t3Valid", pixValid, 1'b1);
      for (int i = 0; i < 16; i++) begin
         forceRead = 1'b1;
         applyStimulus();
      end
      checkOutput("t3Pops", linePops, 16);
      holdCycles = 0;

      // Fifth pixel comes back offscreen with data 0xBEEF.
      doReset();
      offIdx   = 4;
      autoRead = 1'b1;
      pulseLine(1'b1);
      n = 0;
      while (linePops < 6 && n < 300) begin
         applyStimulus();
         n++;
      end
      checkOutput("t4Pop5Rgb", popRgbLog[4], 16'hBEEF);
      checkOutput("t4Pop5Off", popOffLog[4], 1'b1);
      checkOutput("t4Pop4Rgb", popRgbLog[3], 16'h1003);
      checkOutput("t4Pop4Off", popOffLog[3], 1'b0);
      offIdx = -1;

      // Line start while waiting for pixel 100.
      doReset();
      autoRead = 1'b1;
      pulseLine(1'b1);
      n = 0;
      while (lineReqs < 101 && n < 2000) begin
         applyStimulus();
         n++;
      end
      checkOutput("t5ReachedPix100", lineReqs, 101);
      discardNext = 1'b1;
      movesBefore = totalMoves;
      pulseLine(1'b0);
      checkOutput("t5NoMoveInWait", pixMove, 1'b0);
      n = 0;
      while (!seedSeen && n < 20) begin
         applyStimulus();
         n++;
      end
      checkOutput("t5SeedReached", seedSeen, 1'b1);
      checkOutput("t5SeedLineStart", seedLineStart, 1'b1);
      checkOutput("t5SeedNoStart", seedStart, 1'b0);
      checkOutput("t5SeedMove", pixMove, 1'b1);
      checkOutput("t5NoPushMove", totalMoves - movesBefore, 0);
      applyStimulus();
      checkOutput("t5Flushed", pixValid, 1'b0);
      runUntilDone(5000);
      checkOutput("t5Moves", lineMoves, 320);
      repeat (20) applyStimulus();
      checkOutput("t5Pops", linePops, 320);

      // Underflow, its persistence, push+pop at count 8, and the frame clear.
      repeat (5) applyStimulus();
      forceRead = 1'b1;
      applyStimulus();
      applyStimulus();
      checkOutput("t6UnderflowSet", underflow, 1'b1);
      autoRead = 1'b0;
      pulseLine(1'b0);
      checkOutput("t6PlainSeed", seedLineStart, 1'b1);
      repeat (3) applyStimulus();
      checkOutput("t6UnderflowHeldPlain", underflow, 1'b1);
      pairArm = 1'b1;
      repeat (400) applyStimulus();
      checkOutput("t6PairReqs", lineReqs, 17);
      checkOutput("t6Full", pixValid, 1'b1);
      checkOutput("t6UnderflowStill", underflow, 1'b1);
      pulseLine(1'b1);
      checkOutput("t6FrameSeed", seedStart, 1'b1);
      applyStimulus();
      checkOutput("t6UnderflowCleared", underflow, 1'b0);
      checkOutput("t6FlushFull", pixValid, 1'b0);

      checkOutput("strobeRules", violations, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/bg_pix_fifo.md
Name: bg_pix_fifo

Overview:
- Pixel prefetch stage sitting directly downstream of one BG renderer.
- Paces the renderer by issuing its seed, move and request strobes: START/LINE_START with PIX_MOVE, then RGB_REQ.
- Captures each RGB write together with the renderer's offscreen flag into a show-ahead FIFO.
- Delivers pixels to the layer mixer on a read strobe, one scan line per video-timing line start.

Parameters:
- pDEPTH, 16: FIFO entries; power of two, ≥2.
- pLINE_PIX, 320: pixels fetched per line.

Ports:
- iCLOCK  in  1  clock.
- iRESET  in  1  synchronous, active-high reset.
- iFRAME_START  in  1  pulse; qualifies a coincident iLINE_START as line 0 of a frame.
- iLINE_START  in  1  pulse from video timing: begin fetching a new line.
- oPIX_MOVE  out  1  to BG iPIX_MOVE.
- oSTART  out  1  to BG iSTART.
- oLINE_START  out  1  to BG iLINE_START.
- oRGB_REQ  out  1  to BG iRGB_REQ.
- iRGB_WRITE  in  1  from BG oRGB_WRITE; level, may stay high after the write.
- iRGB_WRITE_DATA  in  16  from BG; tRGB.
- iOFFSCREEN  in  1  from BG oOFFSCREEN.
- iPIX_RD  in  1  mixer pops the head entry.
- oPIX_VALID  out  1  FIFO not empty.
- oPIX_RGB  out  16  head RGB.
- oPIX_OFFSCREEN  out  1  head offscreen flag.
- oLINE_DONE  out  1  all pLINE_PIX pixels of the current line have been pushed.
- oUNDERFLOW  out  1  sticky error flag.

Behaviour:
Reset:
- State sIDLE; FIFO empty; pixel counter 0.
- All strobes 0; oPIX_VALID 0; oPIX_RGB 0; oPIX_OFFSCREEN 1; oLINE_DONE 0; oUNDERFLOW 0.

States:
- sIDLE: wait for iLINE_START.
- sSEED: one cycle. oPIX_MOVE=1. oSTART=1 if the latched line start had iFRAME_START, else oLINE_START=1. Counter cleared. FIFO flushed in the same cycle. → sREQ.
- sREQ: if FIFO count < pDEPTH, oRGB_REQ=1 for exactly one cycle → sWAIT; otherwise hold in sREQ with oRGB_REQ=0.
- sWAIT: sample iRGB_WRITE only here. On iRGB_WRITE=1, push {iOFFSCREEN, iRGB_WRITE_DATA} and increment the counter → sMOVE. iRGB_WRITE observed in any other state is ignored.
- sMOVE: one cycle, oPIX_MOVE=1.
  - If counter == pLINE_PIX → sDONE.
  - Else → sREQ.
  - On the last pixel, PIX_MOVE is still issued: the renderer's position is reseeded at the next line start anyway.
- sDONE: oLINE_DONE=1; wait for iLINE_START → sSEED.

Request and strobe rules:
- At most one request outstanding. A push therefore never meets a full FIFO.
- Minimum cadence: 3 cycles per pixel plus renderer latency.
- oSTART and oLINE_START are never asserted without oPIX_MOVE, and never both in the same cycle.

Mid-line iLINE_START (any state except sIDLE and sDONE):
- Latch it as pending together with its frame flag; a later pulse overwrites the latched frame flag.
- In sREQ or sMOVE: go to sSEED next cycle.
- In sWAIT: stay until iRGB_WRITE, discard that data (no push) → sSEED. The renderer must always complete its fetch.

FIFO:
- Show-ahead: oPIX_RGB and oPIX_OFFSCREEN present the head whenever oPIX_VALID=1.
- iPIX_RD with oPIX_VALID=1 pops at the clock edge.
- A push and a pop in the same cycle leave the count unchanged.
- Read and write pointers are log2(pDEPTH) bits and wrap naturally; count is log2(pDEPTH)+1 bits.
- Flush in sSEED overrides a coincident pop.

Underflow:
- iPIX_RD with oPIX_VALID=0: no pop; oUNDERFLOW set to 1.
- oUNDERFLOW clears only on reset or on sSEED with the frame flag set.
- When empty: oPIX_RGB=0 and oPIX_OFFSCREEN=1, so the mixer treats the pixel as transparent.

Reset mid-operation:
- Returns to the reset values immediately. The next line start reseeds the renderer; a stale renderer fetch completing after reset is ignored.

Test Plan:
- Reset, then frame+line start. Model BG with 4-cycle write latency. → oSTART+oPIX_MOVE for 1 cycle, then 320 pushes in order, then oLINE_DONE=1 with exactly 320 oPIX_MOVE pulses after the seed.
- Mixer never reads, pDEPTH=16. → exactly 16 pushes; oRGB_REQ stays 0 in sREQ. One iPIX_RD → exactly one further request.
- Model holds iRGB_WRITE high for 10 cycles after each write. → exactly one push per request; pixel count equals request count.
- Model returns the 5th pixel with iOFFSCREEN=1, data 0xBEEF. → 5th pop shows oPIX_OFFSCREEN=1, oPIX_RGB=0xBEEF.
- iLINE_START arrives while in sWAIT at pixel 100. → write completes and is not pushed; FIFO flushed; oLINE_START+oPIX_MOVE (oSTART=0); counter restarts at 0.
- iPIX_RD while empty. → oUNDERFLOW=1, held through a plain line start, cleared by the next frame-start seed. Simultaneous push+pop at count 8 stays at 8.
